// File: rtl/cordic_phase_gen.sv
// Phase-accumulator front end for a pipelined CORDIC rotator: issues bursts of
// (xin, yin, angle) samples and tracks the rotator latency to flag results.
module cordic_phase_gen #(
    parameter int unsigned LAT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic        [31:0] cfg_freq,
    input  logic signed [15:0] cfg_amp,
    input  logic        [15:0] burst_len,
    input  logic               start,
    input  logic               stop,
    output logic signed [15:0] xin,
    output logic signed [15:0] yin,
    output logic signed [31:0] angle,
    output logic               out_valid,
    output logic               res_valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [15:0] LAT_M1 = 16'(LAT - 1);

    state_t             r_state;
    state_t             w_next;
    logic               w_issue;
    logic               w_drain_end;
    logic        [31:0] r_phase;
    logic        [31:0] r_freq;
    logic signed [15:0] r_amp;
    logic        [15:0] r_cnt;
    logic        [15:0] r_len;
    logic        [15:0] r_dcnt;
    logic     [LAT-1:0] r_sr;

    assign yin       = '0;
    assign res_valid = r_sr[LAT-1];

    always_comb begin
        w_next      = r_state;
        w_issue     = 1'b0;
        w_drain_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RUN;
            end
            RUN: begin
                // stop suppresses the sample of the cycle in which it is seen
                if (stop) begin
                    w_next = DRAIN;
                end else begin
                    w_issue = 1'b1;
                    if ((r_len != '0) && (r_cnt == r_len - 16'd1)) w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (r_dcnt == LAT_M1) begin
                    w_drain_end = 1'b1;
                    w_next      = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            r_freq    <= '0;
            r_amp     <= '0;
            r_cnt     <= '0;
            r_len     <= '0;
            r_dcnt    <= '0;
            r_sr      <= '0;
            xin       <= '0;
            angle     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            r_state   <= w_next;
            busy      <= (w_next != IDLE);
            done      <= w_drain_end;
            out_valid <= w_issue;

            if (r_state == IDLE && cfg_we) begin
                r_freq <= cfg_freq;
                r_amp  <= cfg_amp;
            end
            if (r_state == IDLE && start) begin
                r_phase <= '0;
                r_cnt   <= '0;
                r_len   <= burst_len;
            end
            if (w_issue) begin
                angle   <= r_phase;
                xin     <= r_amp;
                r_phase <= r_phase + r_freq;
                r_cnt   <= r_cnt + 16'd1;
            end

            if (r_state == DRAIN) r_dcnt <= r_dcnt + 16'd1;
            else                  r_dcnt <= '0;

            // res_valid is out_valid seen LAT edges later
            r_sr[0] <= out_valid;
            for (int unsigned i = 1; i < LAT; i++) r_sr[i] <= r_sr[i-1];
        end
    end

endmodule

// File: doc/cordic_phase_gen.md
CORDIC_PHASE_GEN -- requirements
Module: cordic_phase_gen

Interface
REQ-001 Parameter LAT, default 16, cycles from issuing an angle to the matching xout/yout of the downstream CORDIC rotator.
REQ-002 Port clk input 1: single clock, all state updates on rising edge.
REQ-003 Port rst_n input 1: reset is asynchronous and active-low.
REQ-004 Port cfg_we input 1: load cfg_freq/cfg_amp this cycle.
REQ-005 Port cfg_freq input 32: unsigned phase increment per sample, 2^32 = 360 deg.
REQ-006 Port cfg_amp input 16 signed: vector magnitude driven on xin.
REQ-007 Port burst_len input 16: samples per burst, sampled on start; 0 = continuous.
REQ-008 Port start input 1: begin a burst (level sampled, single-cycle pulse expected).
REQ-009 Port stop input 1: end issuing early.
REQ-010 Port xin output 16 signed: CORDIC x input.
REQ-011 Port yin output 16 signed: CORDIC y input, always 0.
REQ-012 Port angle output 32 signed: CORDIC angle input, same 2^32 = 360 deg scale (0x40000000 = 90 deg).
REQ-013 Port out_valid output 1: angle/xin/yin carry a live sample this cycle.
REQ-014 Port res_valid output 1: out_valid delayed exactly LAT cycles; marks valid xout/yout.
REQ-015 Port busy output 1: FSM not in IDLE.
REQ-016 Port done output 1: one-cycle pulse when burst fully flushed.

Function
REQ-017 FSM states IDLE, RUN, DRAIN; all outputs registered.
REQ-018 cfg_we honoured only in IDLE; ignored in RUN/DRAIN (configuration frozen during a burst).
REQ-019 IDLE + start: next cycle state RUN, phase accumulator = 0, sample counter = 0, burst_len latched; stop ignored in IDLE.
REQ-020 RUN: each cycle angle = phase, xin = amp register, out_valid = 1; then phase += freq modulo 2^32 (carry discarded), counter += 1.
REQ-021 First sample after start has angle = 0x00000000; sample n has angle = n*cfg_freq mod 2^32.
REQ-022 RUN -> DRAIN after issuing sample burst_len-1 (burst_len != 0), or on the cycle stop is sampled high; stop-cycle sample is not issued (out_valid = 0 that cycle).
REQ-023 burst_len = 0: RUN continues until stop; counter wraps 0xFFFF -> 0 without effect.
REQ-024 start sampled in RUN/DRAIN is ignored.
REQ-025 DRAIN: out_valid = 0, angle holds last value; waits LAT cycles counted from entry, then done = 1 for one cycle and state IDLE.
REQ-026 res_valid generated by a LAT-deep shift register of out_valid, running in all states; count of res_valid pulses per burst equals count of out_valid pulses.
REQ-027 done asserts in the same cycle as or after the last res_valid of the burst, never before.
REQ-028 busy = 1 in RUN and DRAIN, including the done cycle's preceding state; 0 in IDLE.

Reset
REQ-029 rst_n low asynchronously forces IDLE, phase = 0, counter = 0, freq = 0, amp = 0, shift register cleared; outputs xin = 0, yin = 0, angle = 0, out_valid = 0, res_valid = 0, busy = 0, done = 0.
REQ-030 Reset mid-RUN or mid-DRAIN discards the burst; no done pulse, no residual res_valid after release.

Verification
REQ-031 cfg_freq = 0x10000000, cfg_amp = 0x4000, burst_len = 4, start -> out_valid 4 cycles, angles 0x0, 0x10000000, 0x20000000, 0x30000000, xin = 0x4000; res_valid 4 cycles starting LAT cycles after first out_valid; done one pulse.
REQ-032 cfg_freq = 0xC0000000, burst_len = 3 -> angles 0x0, 0xC0000000, 0x80000000 (wrap verified).
REQ-033 burst_len = 0, stop asserted 10 cycles after start -> exactly 10 (or defined count per REQ-022) out_valid pulses, equal res_valid count, done LAT cycles after entering DRAIN.
REQ-034 cfg_we with new freq during RUN, and start during DRAIN -> both ignored; angle sequence and done timing unchanged.
REQ-035 rst_n pulsed low mid-RUN -> all outputs 0 immediately, no res_valid/done afterwards; fresh start after release begins at angle 0.
